// File: rtl/arbitrated_memory_pkg.sv
// Shared types and sizing helpers for the arbitrated backing memory.
// Imported by the interface, the arbiter and the top.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int cnt_width(input int rl, input int wl);
        int m;
        m = (rl > wl) ? rl : wl;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arbitrated_memory_if.sv
// Request/response bundle between the cache controllers and the memory.
// Per-port fields are packed, port i in slice i.
interface arbitrated_memory_if
    import mem_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
);
    localparam int SW = strb_width(DATA_WIDTH);

    logic [NUM_PORTS-1:0]               req_valid;
    logic [NUM_PORTS-1:0]               req_ready;
    logic [NUM_PORTS-1:0]               req_write;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    req_data;
    logic [NUM_PORTS*SW-1:0]            req_strb;
    logic [NUM_PORTS-1:0]               resp_valid;
    logic                               resp_is_write;
    logic [DATA_WIDTH-1:0]              resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_data, req_strb,
        input  req_ready, resp_valid, resp_is_write, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, req_strb,
        output req_ready, resp_valid, resp_is_write, resp_data
    );

endinterface

// File: rtl/arbitrated_memory_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching from
// the pointer upward; the pointer moves past the winner on advance.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int  NUM_PORTS = 2,
    localparam int PW        = idx_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PW-1:0]        ptr_o
);

    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        ptr_d;
    logic [PW-1:0]        gidx;
    logic [NUM_PORTS-1:0] grant_d;
    logic                 found;
    int                   idx;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        grant_d = '0;
        gidx    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr_q) + k) % NUM_PORTS;
            if (!found && req_i[idx]) begin
                grant_d[idx] = 1'b1;
                gidx         = PW'(idx);
                found        = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Pointer register, cleared to port 0 on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o = grant_d;
    assign ptr_o   = ptr_q;

endmodule

// File: rtl/arbitrated_memory.sv
// Shared word memory serving NUM_PORTS requesters one transaction at a
// time, with fixed read/write latencies and a response per transaction.
module arbitrated_memory
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_PORTS     = 2,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 1,
    parameter int INIT_STEP     = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    arbitrated_memory_if.slave  bus
);

    localparam int SW          = strb_width(DATA_WIDTH);
    localparam int CW          = cnt_width(READ_LATENCY, WRITE_LATENCY);
    localparam int PW          = idx_width(NUM_PORTS);
    localparam int MEMORY_SIZE = 1 << ADDRESS_WIDTH;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     write_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [SW-1:0]            strb_q;
    logic [NUM_PORTS-1:0]     port_q;
    logic [NUM_PORTS-1:0]     resp_valid_q;
    logic                     resp_is_write_q;
    logic [DATA_WIDTH-1:0]    resp_data_q;
    logic [DATA_WIDTH-1:0]    mem_q [MEMORY_SIZE];

    logic [NUM_PORTS-1:0]     grant;
    logic [PW-1:0]            arb_ptr;
    logic                     accept;
    logic                     done;
    logic                     sel_write;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [SW-1:0]            sel_strb;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (bus.req_valid),
        .advance_i (accept),
        .grant_o   (grant),
        .ptr_o     (arb_ptr)
    );

    assign bus.req_ready = grant
        & {NUM_PORTS{(state_q == IDLE) && reset_n}};
    assign accept        = (state_q == IDLE) && (|grant);

    // The pointer must always name a real port.
    always_comb begin
        assert (int'(arb_ptr) < NUM_PORTS);
    end

    // Mux the granted port's request fields.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = bus.req_strb[i*SW +: SW];
            end
        end
    end

    // Next state and latency countdown; done marks the completing edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = sel_write ? CW'(WRITE_LATENCY - 1)
                                        : CW'(READ_LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured request and registered response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            write_q         <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            strb_q          <= '0;
            port_q          <= '0;
            resp_valid_q    <= '0;
            resp_is_write_q <= 1'b0;
            resp_data_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= sel_write;
                addr_q  <= sel_addr;
                data_q  <= sel_data;
                strb_q  <= sel_strb;
                port_q  <= grant;
            end
            resp_valid_q    <= done ? port_q : '0;
            resp_is_write_q <= done && write_q;
            resp_data_q     <= (done && !write_q) ? mem_q[addr_q] : '0;
        end
    end

    // Storage: reloads the ramp pattern on reset, byte-masked writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEMORY_SIZE; i++) begin
                mem_q[i] <= DATA_WIDTH'(i * INIT_STEP);
            end
        end else if (done && write_q) begin
            for (int b = 0; b < SW; b++) begin
                if (strb_q[b]) begin
                    mem_q[addr_q][b*8 +: 8] <= data_q[b*8 +: 8];
                end
            end
        end
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_is_write = resp_is_write_q;
    assign bus.resp_data     = resp_data_q;

endmodule

// File: tb/tb_arbitrated_memory.sv
// Directed bench for arbitrated_memory: latency, strobes, round robin
// and reset abort, with hand-computed expectations.
module tb_arbitrated_memory;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    arbitrated_memory_if #(
        .NUM_PORTS(2), .ADDRESS_WIDTH(6), .DATA_WIDTH(32)
    ) bus ();

    arbitrated_memory #(
        .ADDRESS_WIDTH(6), .DATA_WIDTH(32), .NUM_PORTS(2),
        .READ_LATENCY(4), .WRITE_LATENCY(1), .INIT_STEP(10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xact(input string tag, input int p, input bit w,
                        input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int lat,
                        input logic [31:0] exp_d, input int exp_wait);
        int n;
        int k;
        bus.req_write[p]          = w;
        bus.req_addr[p*6 +: 6]    = a;
        bus.req_data[p*32 +: 32]  = d;
        bus.req_strb[p*4 +: 4]    = s;
        bus.req_valid[p]          = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[p] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_wait >= 0) check({tag, "_wait"}, 64'(n), 64'(exp_wait));
        if (n >= 20) begin
            check({tag, "_ready_timeout"}, 64'd0, 64'd1);
            bus.req_valid[p] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid[p] = 1'b0;
        k = 0;
        while (bus.resp_valid == '0 && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_port"}, 64'(bus.resp_valid), 64'(1) << p);
        check({tag, "_iswr"}, 64'(bus.resp_is_write), 64'(w));
        check({tag, "_data"}, 64'(bus.resp_data), 64'(exp_d));
        @(posedge clk);
        #1 check({tag, "_pulse"}, 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hp [4];
        int hc [4];
        int rv [4];
        logic [31:0] rd [4];
        int nh;
        int nr;
        int seen;
        int n;

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_strb  = '0;

        // Reset state, ready held low even with a request pending
        bus.req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rvalid", 64'(bus.resp_valid), 64'd0);
        check("rst_iswr", 64'(bus.resp_is_write), 64'd0);
        check("rst_rdata", 64'(bus.resp_data), 64'd0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        xact("rd5", 0, 1'b0, 6'd5, 32'h0, 4'h0, 4, 32'd50, 0);
        xact("wr3", 1, 1'b1, 6'd3, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 0);
        xact("rd3", 0, 1'b0, 6'd3, 32'h0, 4'h0, 4, 32'h00BB00DD, 0);
        xact("wr7z", 0, 1'b1, 6'd7, 32'hFFFFFFFF, 4'b0000, 1, 32'h0, 0);
        xact("rd7", 1, 1'b0, 6'd7, 32'h0, 4'h0, 4, 32'd70, 0);
        // Pointer is 0 here: port 1 alone must still win at once
        xact("p1solo", 1, 1'b0, 6'd2, 32'h0, 4'h0, 4, 32'd20, 0);

        // Both ports hammer reads; pointer wrapped to 0 so port 0 first
        bus.req_write = '0;
        bus.req_addr[0 +: 6] = 6'd1;
        bus.req_addr[6 +: 6] = 6'd2;
        bus.req_valid = 2'b11;
        nh = 0;
        nr = 0;
        for (int t = 0; t < 60 && nr < 4; t++) begin
            @(negedge clk);
            if (bus.resp_valid != '0 && nr < 4) begin
                rv[nr] = int'(bus.resp_valid);
                rd[nr] = bus.resp_data;
                nr++;
            end
            if ((bus.req_ready & bus.req_valid) != '0 && nh < 4) begin
                hp[nh] = int'(bus.req_ready);
                hc[nh] = cyc;
                nh++;
                if (nh == 4) begin
                    @(posedge clk);
                    #1 bus.req_valid = '0;
                end
            end
        end
        bus.req_valid = '0;
        check("rr_nhs", 64'(nh), 64'd4);
        check("rr_nresp", 64'(nr), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant%0d", i), 64'(hp[i]),
                  (i % 2 == 0) ? 64'd1 : 64'd2);
            check($sformatf("rr_rport%0d", i), 64'(rv[i]),
                  (i % 2 == 0) ? 64'd1 : 64'd2);
            check($sformatf("rr_rdata%0d", i), 64'(rd[i]),
                  (i % 2 == 0) ? 64'd10 : 64'd20);
            if (i > 0) begin
                check($sformatf("rr_gap%0d", i), 64'(hc[i] - hc[i-1]),
                      64'd5);
            end
        end
        @(posedge clk);
        #1;

        // Cross-port ordering: write from 0, read back from 1
        xact("wr5", 0, 1'b1, 6'd5, 32'h12345678, 4'hF, 1, 32'h0, -1);
        xact("rd5x", 1, 1'b0, 6'd5, 32'h0, 4'h0, 4, 32'h12345678, -1);

        // Reset two cycles into a read: response must never appear
        bus.req_write[0]     = 1'b0;
        bus.req_addr[0 +: 6] = 6'd5;
        bus.req_valid[0]     = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_ready", 64'(bus.req_ready[0]), 64'd1);
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        bus.req_valid[1] = 1'b1;
        seen = 0;
        @(negedge clk);
        check("abort_rst_ready", 64'(bus.req_ready), 64'd0);
        if (bus.resp_valid != '0) seen++;
        @(negedge clk);
        if (bus.resp_valid != '0) seen++;
        @(posedge clk);
        #1 bus.req_valid = '0;
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid != '0) seen++;
        end
        check("abort_noresp", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        xact("rd5rst", 0, 1'b0, 6'd5, 32'h0, 4'h0, 4, 32'd50, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
